cpu_mul_seq: RTL and testbench
==============================

CPU_MUL_SEQ -- requirements
Module: cpu_mul_seq

Interface
REQ-001 SHALL have one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-002 Parameters: none; op codes SHALL come from the shared operations header (OP_ADD, OP_PASS_A, OP_SHR_A, OP_CLR_A).
REQ-003 Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  async active-low reset
- start_i  in  1  request multiply; accepted only in IDLE
- abort_i  in  1  cancel in-flight multiply
- mcand_i  in  8  multiplicand, sampled on accept
- mplier_i  in  8  multiplier, sampled on accept
- alu_a_o  out  8  ALU operand A
- alu_b_o  out  8  ALU operand B
- alu_op_o  out  5  ALU operation select
- alu_y_i  in  8  ALU result
- alu_c_i  in  1  ALU carry flag
- busy_o  out  1  high in ADD/SHIFT
- done_o  out  1  one-cycle completion pulse
- prod_o  out  16  unsigned product, held until next accept
- z_o  out  1  prod_o == 0
- hi_nz_o  out  1  prod_o[15:8] != 0 (8-bit overflow indicator)

Function
REQ-004 SHALL compute the unsigned 8x8 product by shift-add, using the external ALU for every add and shift; no internal adder on the product path.
REQ-005 State registers: FSM state, M[7:0], P_hi[7:0], P_lo[7:0], cbit, cnt[2:0].
REQ-006 States SHALL be IDLE, ADD, SHIFT, DONE.
REQ-007 IDLE: start_i=1 -> M<=mcand_i, P_hi<=0, P_lo<=mplier_i, cbit<=0, cnt<=0, go to ADD; else stay.
REQ-008 ADD: P_lo[0]=1 -> alu_op_o=OP_ADD, alu_a_o=P_hi, alu_b_o=M; P_lo[0]=0 -> alu_op_o=OP_PASS_A, alu_a_o=P_hi, alu_b_o=0; P_hi<=alu_y_i, cbit<=alu_c_i; go to SHIFT.
REQ-009 SHIFT: alu_op_o=OP_SHR_A, alu_a_o=P_hi, alu_b_o=0; P_hi<={cbit, alu_y_i[6:0]}; P_lo<={alu_c_i, P_lo[7:1]}; cnt<=cnt+1; cnt=7 -> DONE, else ADD.
REQ-010 DONE: done_o=1 for exactly this cycle; next state IDLE; start_i ignored.
REQ-011 IDLE/DONE: alu_op_o=OP_CLR_A, alu_a_o=0, alu_b_o=0.
REQ-012 Latency SHALL be fixed: accept at edge N -> done_o high during the cycle following edge N+16, independent of operands.
REQ-013 prod_o={P_hi,P_lo} SHALL be presented only in DONE and after; during ADD/SHIFT prod_o, z_o, hi_nz_o SHALL hold the previous result.
REQ-014 Product register updates at the DONE transition; z_o and hi_nz_o derive from the held product.
REQ-015 start_i while busy or in DONE SHALL be ignored (no queuing).
REQ-016 abort_i=1 in ADD/SHIFT -> IDLE at next edge, no done_o, prod_o unchanged; abort_i in IDLE/DONE has no effect.
REQ-017 Simultaneous start_i and abort_i in IDLE: start wins.
REQ-018 All outputs SHALL be registered state or decoded from state only; no combinational path from start_i or abort_i to any output.

Reset
REQ-019 rst_ni low SHALL asynchronously force IDLE, cnt=0, cbit=0, M=P_hi=P_lo=0, prod_o=0, busy_o=0, done_o=0, z_o=1, hi_nz_o=0, alu_op_o=OP_CLR_A, alu_a_o=alu_b_o=0.
REQ-020 Reset mid-operation SHALL discard the operation; no done_o follows reset release.
REQ-021 First accept SHALL be possible on the first rising edge after rst_ni deasserts.

Verification (bench instantiates cpu_alu as the ALU)
REQ-022 start, 0x0F x 0x11 -> done_o 16 cycles after accept, prod_o=0x00FF, z_o=0, hi_nz_o=0.
REQ-023 start, 0xFF x 0xFF -> prod_o=0xFE01, hi_nz_o=1; covers the ADD carry into P_hi MSB.
REQ-024 start, 0x00 x 0x5A -> prod_o=0x0000, z_o=1; start again, 0x80 x 0x02 -> prod_o=0x0100.
REQ-025 abort_i pulsed 5 cycles after accept -> busy_o low next cycle, no done_o, prod_o keeps the prior value; start_i asserted in DONE -> ignored.
REQ-026 rst_ni pulled low mid-multiply -> all outputs at REQ-019 values immediately; after release, 0x03 x 0x07 -> prod_o=0x0015.

Source files
------------

// File: rtl/cpu_ops_pkg.sv
// Shared ALU operation codes used by the sequencer and the ALU.
// The numbering is chosen so that an all-zero op bus means OP_CLR_A.
package cpu_ops_pkg;
    localparam logic [4:0] OP_CLR_A  = 5'h00;
    localparam logic [4:0] OP_ADD    = 5'h01;
    localparam logic [4:0] OP_PASS_A = 5'h02;
    localparam logic [4:0] OP_SHR_A  = 5'h03;
endpackage

// File: rtl/cpu_alu.sv
// Purpose: 8-bit combinational ALU serving the shift-add sequencer.
// Latency: 0 cycles. There is no flow control; the result follows the operands.
module cpu_alu
    import cpu_ops_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [4:0] op_i,
    output logic [7:0] y_o,
    output logic       c_o
);

    always_comb begin
        y_o = '0;
        c_o = 1'b0;
        case (op_i)
            OP_ADD:    {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_PASS_A: y_o = a_i;
            OP_SHR_A: begin
                y_o = {1'b0, a_i[7:1]};
                c_o = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_mul_seq.sv
// Purpose: unsigned 8x8 shift-add multiplier that uses an external ALU for every add and shift.
// Latency: done_o rises 16 cycles after accept. start_i is dropped, not queued, while busy or in DONE.
module cpu_mul_seq
    import cpu_ops_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [7:0]  mcand_i,
    input  logic [7:0]  mplier_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [4:0]  alu_op_o,
    input  logic [7:0]  alu_y_i,
    input  logic        alu_c_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] prod_o,
    output logic        z_o,
    output logic        hi_nz_o
);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_m;
    logic [7:0]  r_p_hi;
    logic [7:0]  r_p_lo;
    logic        r_cbit;
    logic [2:0]  r_cnt;
    logic [15:0] r_prod;
    logic [7:0]  w_p_hi_shr;
    logic [7:0]  w_p_lo_shr;

    // The ALU shifts P_hi; the saved add carry refills its MSB and the bit shifted out enters P_lo.
    assign w_p_hi_shr = {r_cbit, alu_y_i[6:0]};
    assign w_p_lo_shr = {alu_c_i, r_p_lo[7:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_op_o    = OP_CLR_A;
        alu_a_o     = '0;
        alu_b_o     = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_ADD;
            end
            S_ADD: begin
                alu_a_o = r_p_hi;
                if (r_p_lo[0]) begin
                    alu_op_o = OP_ADD;
                    alu_b_o  = r_m;
                end else begin
                    alu_op_o = OP_PASS_A;
                end
                w_state_nxt = abort_i ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                alu_op_o = OP_SHR_A;
                alu_a_o  = r_p_hi;
                if (abort_i)               w_state_nxt = S_IDLE;
                else if (r_cnt == 3'd7)    w_state_nxt = S_DONE;
                else                       w_state_nxt = S_ADD;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m    <= '0;
            r_p_hi <= '0;
            r_p_lo <= '0;
            r_cbit <= 1'b0;
            r_cnt  <= '0;
            r_prod <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_m    <= mcand_i;
                        r_p_hi <= '0;
                        r_p_lo <= mplier_i;
                        r_cbit <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_ADD: begin
                    r_p_hi <= alu_y_i;
                    r_cbit <= alu_c_i;
                end
                S_SHIFT: begin
                    r_p_hi <= w_p_hi_shr;
                    r_p_lo <= w_p_lo_shr;
                    r_cnt  <= r_cnt + 3'd1;
                    // An abort on the final shift must leave the previous result intact.
                    if (r_cnt == 3'd7 && !abort_i) begin
                        r_prod <= {w_p_hi_shr, w_p_lo_shr};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (r_state == S_ADD) || (r_state == S_SHIFT);
    assign done_o  = (r_state == S_DONE);
    assign prod_o  = r_prod;
    assign z_o     = (r_prod == 16'h0000);
    assign hi_nz_o = |r_prod[15:8];

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Randomised and directed stimulus against cpu_mul_seq with cpu_alu attached;
// the expected products go into a queue that a negedge monitor drains on done_o.
module tb_cpu_mul_seq;
    import cpu_ops_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [7:0]  mcand_i = '0;
    logic [7:0]  mplier_i = '0;
    logic [7:0]  alu_a_o, alu_b_o, alu_y_i;
    logic [4:0]  alu_op_o;
    logic        alu_c_i, busy_o, done_o, z_o, hi_nz_o;
    logic [15:0] prod_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_prod_q[$];
    int          exp_cyc_q[$];
    logic [15:0] held_prod = '0;

    cpu_mul_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .mcand_i(mcand_i), .mplier_i(mplier_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
        .alu_y_i(alu_y_i), .alu_c_i(alu_c_i),
        .busy_o(busy_o), .done_o(done_o), .prod_o(prod_o), .z_o(z_o), .hi_nz_o(hi_nz_o)
    );

    cpu_alu alu (
        .a_i(alu_a_o), .b_i(alu_b_o), .op_i(alu_op_o), .y_o(alu_y_i), .c_o(alu_c_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done_o and otherwise checks the product is held.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (done_o) begin
                if (exp_prod_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    logic [15:0] ep;
                    int          ec;
                    ep = exp_prod_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("prod", 32'(prod_o), 32'(ep));
                    chk("z", 32'(z_o), 32'(ep == 16'h0));
                    chk("hi_nz", 32'(hi_nz_o), 32'(ep[15:8] != 8'h0));
                    chk("done_latency", cyc, ec);
                    held_prod = ep;
                end
            end else if (busy_o) begin
                chk("prod_held", 32'(prod_o), 32'(held_prod));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (!busy_o && !done_o) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (done_o) return;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    // Issues one request at an idle point; the accept edge follows the negedge it is driven on.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit expect_done,
                         input bit abort_too);
        wait_idle();
        mcand_i  = a;
        mplier_i = b;
        start_i  = 1'b1;
        abort_i  = abort_too;
        @(posedge clk_i);
        #1;
        if (expect_done) begin
            exp_prod_q.push_back(16'(a) * 16'(b));
            exp_cyc_q.push_back(cyc + 16);
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_accept", 32'(busy_o), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prod"}, 32'(prod_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_z"}, 32'(z_o), 32'd1);
        chk({tag, "_hi_nz"}, 32'(hi_nz_o), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op_o), 32'(OP_CLR_A));
        chk({tag, "_alu_a"}, 32'(alu_a_o), 32'd0);
        chk({tag, "_alu_b"}, 32'(alu_b_o), 32'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        issue(8'h0F, 8'h11, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        issue(8'h00, 8'h5A, 1'b1, 1'b0);
        issue(8'h80, 8'h02, 1'b1, 1'b0);

        // Abort five cycles into a multiply: no done, previous product stays.
        issue(8'hA5, 8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk_i);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_abort", 32'(busy_o), 32'd0);
        chk("prod_after_abort", 32'(prod_o), 32'h0100);

        // start_i while DONE is visible must be dropped.
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done();
        start_i = 1'b1;
        mcand_i = 8'h55;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk("start_in_done_ignored", 32'(busy_o), 32'd0);

        // Simultaneous start and abort in IDLE: the start is taken.
        issue(8'h9B, 8'hC7, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a multiply.
        issue(8'h77, 8'h66, 1'b0, 1'b0);
        repeat (5) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        held_prod = '0;
        @(negedge clk_i);
        rst_ni   = 1'b1;
        mcand_i  = 8'h03;
        mplier_i = 8'h07;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        exp_prod_q.push_back(16'h0015);
        exp_cyc_q.push_back(cyc + 16);
        start_i = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            if (n % 7 == 0) a = 8'hFF;
            if (n % 5 == 0) b = 8'h01;
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            issue(a, b, 1'b1, 1'b0);
        end

        for (int i = 0; i < 60 && exp_prod_q.size() != 0; i++) @(negedge clk_i);
        chk("queue_drained", exp_prod_q.size(), 32'd0);
        repeat (20) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
